// File: rtl/register_file_sb.sv
// Register file with write-through read bypass, hardwired zero register and a
// per-register pending-write scoreboard for RAW/WAW hazard detection.
module register_file_sb #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Reg_Write_i,
  input  logic [ADDR_W-1:0] Write_Register_i,
  input  logic [N-1:0]      Write_Data_i,
  input  logic [ADDR_W-1:0] Read_Register_1_i,
  input  logic [ADDR_W-1:0] Read_Register_2_i,
  output logic [N-1:0]      Read_Data_1_o,
  output logic [N-1:0]      Read_Data_2_o,
  output logic              Busy_1_o,
  output logic              Busy_2_o,
  input  logic              Reserve_i,
  input  logic [ADDR_W-1:0] Reserve_Register_i,
  output logic              Reserve_Ack_o,
  output logic [ADDR_W:0]   Pending_Count_o,
  output logic [N-1:0]      Q1
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;

  logic [N-1:0]      regs_q [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic wr_en;
  logic wr_hit_1, wr_hit_2, wr_hit_rsv;
  logic rsv_set, wr_clr, cnt_inc, cnt_dec;

  // Decode write/reserve events shared by the read, busy and scoreboard logic.
  always_comb begin
    wr_en      = Reg_Write_i && (Write_Register_i != '0);
    wr_hit_1   = Reg_Write_i && (Write_Register_i == Read_Register_1_i);
    wr_hit_2   = Reg_Write_i && (Write_Register_i == Read_Register_2_i);
    wr_hit_rsv = Reg_Write_i && (Write_Register_i == Reserve_Register_i);
  end

  // Read ports: zero register, then writeback bypass, then stored value.
  always_comb begin
    Read_Data_1_o = '0;
    Read_Data_2_o = '0;
    if (Read_Register_1_i != '0) begin
      Read_Data_1_o = wr_hit_1 ? Write_Data_i : regs_q[Read_Register_1_i];
    end
    if (Read_Register_2_i != '0) begin
      Read_Data_2_o = wr_hit_2 ? Write_Data_i : regs_q[Read_Register_2_i];
    end
  end

  // Busy and reserve handshake; r0 is never pending so it is never busy.
  always_comb begin
    Busy_1_o      = pending_q[Read_Register_1_i] && !wr_hit_1;
    Busy_2_o      = pending_q[Read_Register_2_i] && !wr_hit_2;
    Reserve_Ack_o = Reserve_i && ((Reserve_Register_i == '0) ||
                                  !pending_q[Reserve_Register_i] || wr_hit_rsv);
    Pending_Count_o = count_q;
    Q1              = regs_q[1];
  end

  // Scoreboard next state: a reserve wins over a same-cycle release of the
  // same register, so that case neither sets nor clears the count.
  always_comb begin
    rsv_set   = Reserve_Ack_o && (Reserve_Register_i != '0);
    wr_clr    = wr_en && pending_q[Write_Register_i];
    cnt_inc   = rsv_set && !pending_q[Reserve_Register_i];
    cnt_dec   = wr_clr && !(rsv_set && (Reserve_Register_i == Write_Register_i));
    pending_d = pending_q;
    if (wr_clr) begin
      pending_d[Write_Register_i] = 1'b0;
    end
    if (rsv_set) begin
      pending_d[Reserve_Register_i] = 1'b1;
    end
    count_d = count_q + CntW'(cnt_inc) - CntW'(cnt_dec);
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // Register storage; r0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[Write_Register_i] <= Write_Data_i;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: default 32x32 instance plus a
// 16-bit, 8-entry instance. Expected values go through a scoreboard queue.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        reset;

  logic        rw, rs;
  logic [4:0]  wa, ra1, ra2, rsa;
  logic [31:0] wd, rd1, rd2, q1;
  logic        b1, b2, ack;
  logic [5:0]  cnt;

  logic        s_rw, s_rs;
  logic [2:0]  s_wa, s_ra1, s_ra2, s_rsa;
  logic [15:0] s_wd, s_rd1, s_rd2, s_q1;
  logic        s_b1, s_b2, s_ack;
  logic [3:0]  s_cnt;

  logic [31:0] exp_q [$];
  logic [31:0] exp;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  register_file_sb dut (
    .clk                (clk),
    .reset              (reset),
    .Reg_Write_i        (rw),
    .Write_Register_i   (wa),
    .Write_Data_i       (wd),
    .Read_Register_1_i  (ra1),
    .Read_Register_2_i  (ra2),
    .Read_Data_1_o      (rd1),
    .Read_Data_2_o      (rd2),
    .Busy_1_o           (b1),
    .Busy_2_o           (b2),
    .Reserve_i          (rs),
    .Reserve_Register_i (rsa),
    .Reserve_Ack_o      (ack),
    .Pending_Count_o    (cnt),
    .Q1                 (q1)
  );

  register_file_sb #(.N(16), .ADDR_W(3)) dut_small (
    .clk                (clk),
    .reset              (reset),
    .Reg_Write_i        (s_rw),
    .Write_Register_i   (s_wa),
    .Write_Data_i       (s_wd),
    .Read_Register_1_i  (s_ra1),
    .Read_Register_2_i  (s_ra2),
    .Read_Data_1_o      (s_rd1),
    .Read_Data_2_o      (s_rd2),
    .Busy_1_o           (s_b1),
    .Busy_2_o           (s_b2),
    .Reserve_i          (s_rs),
    .Reserve_Register_i (s_rsa),
    .Reserve_Ack_o      (s_ack),
    .Pending_Count_o    (s_cnt),
    .Q1                 (s_q1)
  );

  task automatic test_reset;
    reset = 1'b0;
    rw = 1'b1; wa = 5'd2; wd = 32'd7; ra1 = 5'd2; ra2 = 5'd0;
    rs = 1'b1; rsa = 5'd4;
    exp_q.push_back(32'd7); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp) begin n_err++; $display("FAIL rst_bypass: got %0h want %0h", rd1, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (ack !== exp[0]) begin n_err++; $display("FAIL rst_ack: got %0b want %0b", ack, exp[0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL rst_cnt: got %0d want %0d", cnt, exp[5:0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (b1 !== exp[0]) begin n_err++; $display("FAIL rst_busy: got %0b want %0b", b1, exp[0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (q1 !== exp) begin n_err++; $display("FAIL rst_q1: got %0h want %0h", q1, exp); end
    // An edge passes while reset is held; neither write nor reserve may land.
    @(negedge clk);
    rw = 1'b0; rs = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp) begin n_err++; $display("FAIL rst_nowrite: got %0h want %0h", rd1, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL rst_norsv: got %0d want %0d", cnt, exp[5:0]); end
    reset = 1'b1;
  endtask

  task automatic test_write_read;
    logic [4:0]  addrs [4];
    logic [31:0] datas [4];
    addrs[0] = 5'd0;  datas[0] = 32'd3;
    addrs[1] = 5'd2;  datas[1] = 32'd7;
    addrs[2] = 5'd4;  datas[2] = 32'd20;
    addrs[3] = 5'd31; datas[3] = 32'd78;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rw = 1'b1; wa = addrs[i]; wd = datas[i];
      exp_q.push_back((addrs[i] == 5'd0) ? 32'd0 : datas[i]);
    end
    @(negedge clk);
    rw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra1 = addrs[i]; ra2 = addrs[i];
      #1;
      exp = exp_q.pop_front(); n_vec += 2;
      if (rd1 !== exp) begin
        n_err++; $display("FAIL rd1_r%0d: got %0d want %0d", addrs[i], rd1, exp);
      end
      if (rd2 !== exp) begin
        n_err++; $display("FAIL rd2_r%0d: got %0d want %0d", addrs[i], rd2, exp);
      end
    end
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_vec++;
    if (q1 !== exp) begin n_err++; $display("FAIL q1_empty: got %0d want %0d", q1, exp); end
    @(negedge clk);
    rw = 1'b1; wa = 5'd1; wd = 32'd5;
    exp_q.push_back(32'd5);
    @(negedge clk);
    rw = 1'b0;
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (q1 !== exp) begin n_err++; $display("FAIL q1_r1: got %0d want %0d", q1, exp); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rs = 1'b1; rsa = 5'd3;
    @(negedge clk);
    rs = 1'b0; rw = 1'b1; wa = 5'd6; wd = 32'hABCD; ra1 = 5'd2; ra2 = 5'd6;
    exp_q.push_back(32'd1);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL pre_rst_cnt: got %0d want %0d", cnt, exp[5:0]); end
    #2;
    reset = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'hABCD);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp) begin n_err++; $display("FAIL mid_rst_r2: got %0h want %0h", rd1, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL mid_rst_cnt: got %0d want %0d", cnt, exp[5:0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (q1 !== exp) begin n_err++; $display("FAIL mid_rst_q1: got %0h want %0h", q1, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp) begin n_err++; $display("FAIL mid_rst_byp: got %0h want %0h", rd2, exp); end
    @(negedge clk);
    rw = 1'b0;
    exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp) begin n_err++; $display("FAIL mid_rst_nowr: got %0h want %0h", rd2, exp); end
    reset = 1'b1;
  endtask

  task automatic test_bypass;
    @(negedge clk);
    rw = 1'b1; wa = 5'd25; wd = 32'd6; ra2 = 5'd25;
    exp_q.push_back(32'd6); exp_q.push_back(32'd6);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp) begin n_err++; $display("FAIL byp_same: got %0d want %0d", rd2, exp); end
    @(negedge clk);
    rw = 1'b0;
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (rd2 !== exp) begin n_err++; $display("FAIL byp_stored: got %0d want %0d", rd2, exp); end
  endtask

  task automatic test_scoreboard;
    @(negedge clk);
    rs = 1'b1; rsa = 5'd4; rw = 1'b0;
    exp_q.push_back(32'd1);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (ack !== exp[0]) begin n_err++; $display("FAIL sb_ack1: got %0b want %0b", ack, exp[0]); end
    @(negedge clk);
    ra1 = 5'd4;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (ack !== exp[0]) begin n_err++; $display("FAIL sb_waw: got %0b want %0b", ack, exp[0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (b1 !== exp[0]) begin n_err++; $display("FAIL sb_busy: got %0b want %0b", b1, exp[0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL sb_cnt1: got %0d want %0d", cnt, exp[5:0]); end
    @(negedge clk);
    rs = 1'b0; rw = 1'b1; wa = 5'd4; wd = 32'd9;
    exp_q.push_back(32'd0); exp_q.push_back(32'd9); exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (b1 !== exp[0]) begin n_err++; $display("FAIL sb_busy_wr: got %0b want %0b", b1, exp[0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp) begin n_err++; $display("FAIL sb_byp: got %0d want %0d", rd1, exp); end
    @(negedge clk);
    // A further write to the now non-pending r4 must not underflow the count.
    wa = 5'd4; wd = 32'd10;
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL sb_cnt0: got %0d want %0d", cnt, exp[5:0]); end
    @(negedge clk);
    rw = 1'b0;
    exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL sb_nounder: got %0d want %0d", cnt, exp[5:0]); end
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    rs = 1'b1; rsa = 5'd2;
    @(negedge clk);
    rs = 1'b1; rsa = 5'd2; rw = 1'b1; wa = 5'd2; wd = 32'd11; ra1 = 5'd2;
    exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    exp_q.push_back(32'd11);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (ack !== exp[0]) begin n_err++; $display("FAIL sim_ack_same: got %0b want %0b", ack, exp[0]); end
    @(negedge clk);
    rs = 1'b1; rsa = 5'd5; rw = 1'b0;
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL sim_cnt_same: got %0d want %0d", cnt, exp[5:0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (b1 !== exp[0]) begin n_err++; $display("FAIL sim_r2_pend: got %0b want %0b", b1, exp[0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (rd1 !== exp) begin n_err++; $display("FAIL sim_r2_data: got %0d want %0d", rd1, exp); end
    // r2, r5 pending; reserve r3 while releasing r5.
    @(negedge clk);
    rs = 1'b1; rsa = 5'd3; rw = 1'b1; wa = 5'd5; wd = 32'd1;
    exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    @(negedge clk);
    rs = 1'b1; rsa = 5'd0; rw = 1'b0; ra1 = 5'd3; ra2 = 5'd5;
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL sim_cnt_ab: got %0d want %0d", cnt, exp[5:0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (b1 !== exp[0]) begin n_err++; $display("FAIL sim_r3_pend: got %0b want %0b", b1, exp[0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (b2 !== exp[0]) begin n_err++; $display("FAIL sim_r5_free: got %0b want %0b", b2, exp[0]); end
    exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    exp = exp_q.pop_front(); n_vec++;
    if (ack !== exp[0]) begin n_err++; $display("FAIL sim_ack_r0: got %0b want %0b", ack, exp[0]); end
    @(negedge clk);
    rs = 1'b0; rw = 1'b1; wa = 5'd7; wd = 32'd2;
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL sim_cnt_r0: got %0d want %0d", cnt, exp[5:0]); end
    @(negedge clk);
    rw = 1'b0;
    exp_q.push_back(32'd2);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (cnt !== exp[5:0]) begin n_err++; $display("FAIL sim_cnt_nonpend: got %0d want %0d", cnt, exp[5:0]); end
  endtask

  task automatic test_small_param;
    @(negedge clk);
    s_rw = 1'b1; s_wa = 3'd7; s_wd = 16'hFFFF;
    exp_q.push_back(32'h0000FFFF);
    @(negedge clk);
    s_rw = 1'b0; s_ra1 = 3'd7;
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (s_rd1 !== exp[15:0]) begin n_err++; $display("FAIL sm_r7: got %0h want %0h", s_rd1, exp[15:0]); end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      s_rs = 1'b1; s_rsa = 3'(i);
      exp_q.push_back(32'd1);
      #1;
      exp = exp_q.pop_front(); n_vec++;
      if (s_ack !== exp[0]) begin
        n_err++; $display("FAIL sm_ack_r%0d: got %0b want %0b", i, s_ack, exp[0]);
      end
    end
    @(negedge clk);
    s_rsa = 3'd7;
    exp_q.push_back(32'd7); exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (s_cnt !== exp[3:0]) begin n_err++; $display("FAIL sm_cnt7: got %0d want %0d", s_cnt, exp[3:0]); end
    exp = exp_q.pop_front(); n_vec++;
    if (s_ack !== exp[0]) begin n_err++; $display("FAIL sm_waw: got %0b want %0b", s_ack, exp[0]); end
    s_rs = 1'b0;
  endtask

  initial begin
    rw = 1'b0; rs = 1'b0; wa = '0; ra1 = '0; ra2 = '0; rsa = '0; wd = '0;
    s_rw = 1'b0; s_rs = 1'b0; s_wa = '0; s_ra1 = '0; s_ra2 = '0; s_rsa = '0; s_wd = '0;
    test_reset();
    test_write_read();
    test_reset_mid();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_small_param();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised successor to the single-issue register file. It adds write-through read bypass, a hardwired zero register and a per-register pending-write scoreboard so a pipelined datapath can detect RAW/WAW hazards. Sits between decode (read, reserve) and writeback (write, release) in the pipelined MIPS core. Provides two combinational read ports, one synchronous write port, one reserve port and a debug tap.

## Interface
- N, 32, data width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W registers
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  asynchronous, active-low; clears all state
- Reg_Write_i  input  1  writeback enable
- Write_Register_i  input  ADDR_W  writeback address
- Write_Data_i  input  N  writeback data
- Read_Register_1_i  input  ADDR_W  read port 1 address
- Read_Register_2_i  input  ADDR_W  read port 2 address
- Read_Data_1_o  output  N  read port 1 data, combinational
- Read_Data_2_o  output  N  read port 2 data, combinational
- Busy_1_o  output  1  register addressed by port 1 has a pending write not satisfied this cycle
- Busy_2_o  output  1  same for port 2
- Reserve_i  input  1  request to mark a destination register pending
- Reserve_Register_i  input  ADDR_W  destination to reserve
- Reserve_Ack_o  output  1  reserve accepted this cycle, combinational
- Pending_Count_o  output  ADDR_W+1  number of registers currently pending
- Q1  output  N  contents of register 1 (debug)

## Operation
- Storage: DEPTH x N registers plus DEPTH pending bits and a pending counter.
- Register 0: always reads 0. Writes to it are ignored. It is never pending and never busy.
- Write: at a rising clk with Reg_Write_i=1 and Write_Register_i≠0, the register takes Write_Data_i. The same edge clears that register's pending bit unless a simultaneous accepted reserve targets the same address.
- Read: Read_Data_k_o = 0 if the address is 0.
  - Else Write_Data_i if Reg_Write_i=1 and Write_Register_i equals the read address (bypass).
  - Else the stored value.
- Busy_k_o = pending[addr] AND NOT (Reg_Write_i AND Write_Register_i==addr). It is 0 for addr 0.
- Reserve_Ack_o = Reserve_i AND (Reserve_Register_i==0 OR !pending[addr] OR (Reg_Write_i AND Write_Register_i==addr)).
  - A reserve is refused while an earlier producer to the same register is still outstanding; this is the WAW guard.
  - Decode must hold the request until it is acked.
- Accepted reserve: sets pending[addr] at the edge. A reserve to address 0 is acked but has no effect.
- Pending_Count_o: incremented by a bit set and decremented by a bit cleared.
  - Set and clear of the same register in one cycle leave the count unchanged.
  - Set of A and clear of B in one cycle leave it unchanged.
  - The count never exceeds DEPTH-1 and never underflows.
  - A write to a non-pending register does not decrement.
- Q1 mirrors stored register 1 and is not bypassed.
- Reset (asserted low, at any time, including mid-write): all registers, pending bits and the counter go to 0 immediately.
  - Outputs under reset: Read_Data_*_o = bypass value or 0; Busy_*_o=0; Reserve_Ack_o follows Reserve_i; Pending_Count_o=0; Q1=0.
  - No write or reserve takes effect while reset=0.

## Timing
- Write latency: 1 cycle to storage; 0 cycles to a read port via bypass.
- Reserve takes effect at the next rising edge. Busy is visible on reads in the cycle after acceptance.
- Reads, Busy and Reserve_Ack are purely combinational from the current inputs and state.
- Release of reset is synchronous to clk from the bench's view: first effective edge is the first rising clk with reset=1.

## Test plan
- Reset: drive reset=0 mid-run after writing 7 to r2 -> Read_Data_1_o(r2)=0, Pending_Count_o=0 and Q1=0 immediately, without waiting for clk.
- Write/read and r0:
  - Write 3 to r0, then 7 to r2, 20 to r4, 78 to r31 on consecutive edges.
  - Expect: r0 reads 0; r2=7, r4=20, r31=78 on both ports; Q1=0.
  - Then write 5 to r1 -> Q1=5.
- Bypass: Reg_Write_i=1, r25←6, Read_Register_2_i=25 in the same cycle -> Read_Data_2_o=6 before the edge; the stored value matches after the edge.
- Scoreboard:
  - Reserve r4 -> Ack=1; next cycle Busy_1_o=1 for r4 and Pending_Count_o=1.
  - Second reserve of r4 -> Ack=0.
  - Write r4=9 -> Busy_1_o=0 in that cycle, data 9 bypassed; count goes to 0 after the edge.
- Simultaneous events:
  - Reserve r2 while pending r2 is written in the same cycle -> Ack=1; r2 stays pending and count is unchanged.
  - Reserve r3 while writing pending r5 -> count unchanged.
  - Reserve r0 -> Ack=1, count unchanged.
- Parameters: N=16, ADDR_W=3 -> write 0xFFFF to r7, read 0xFFFF; reserve r1..r7 -> Pending_Count_o=7.
